// File: rtl/sram_arbiter_2p.sv
// sram_arbiter_2p: shares one single-port SRAM macro between two requesters.
// Round-robin grant among eligible ports, one access per cycle. Reads are
// tracked for one cycle (macro latency) and then parked in a 2-entry
// per-port response FIFO. A port may only issue a read while it holds a
// credit, so a stalled response channel can never lose data.
module sram_arbiter_2p #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              req_valid_i,
   output logic [1:0]              req_ready_o,
   input  logic [1:0]              req_we_i,
   input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
   input  logic [2*DATA_WIDTH-1:0] req_be_i,
   output logic [1:0]              rsp_valid_o,
   input  logic [1:0]              rsp_ready_i,
   output logic [2*DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                    sram_ce_o,
   output logic                    sram_we_o,
   output logic [ADDR_WIDTH-1:0]   sram_addr_o,
   output logic [DATA_WIDTH-1:0]   sram_wdata_o,
   output logic [DATA_WIDTH-1:0]   sram_be_o,
   input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

   // A read needs a free slot counting both parked data and the read in flight.
   function automatic logic has_credit(input logic [1:0] cnt, input logic infl);
      logic [2:0] used;
      used = {1'b0, cnt} + {2'b00, infl};
      return used < 3'd2;
   endfunction

   logic                  rr_ptr;
   logic [1:0]            eligible;
   logic [1:0]            grant;
   logic                  sel;
   logic                  read_issue;

   logic                  rd_vld_p1;
   logic                  rd_port_p1;
   logic [1:0]            infl;

   logic [1:0]            count [2];
   logic                  wr_ptr [2];
   logic                  rd_ptr [2];
   logic [DATA_WIDTH-1:0] fifo_mem [2][2];
   logic [1:0]            push;
   logic [1:0]            pop;

   assign infl[0] = rd_vld_p1 && !rd_port_p1;
   assign infl[1] = rd_vld_p1 &&  rd_port_p1;

   // Eligibility and round-robin grant; nothing is granted while in reset.
   always_comb begin
      eligible = 2'b00;
      grant    = 2'b00;
      for (int p = 0; p < 2; p++) begin
         eligible[p] = rst_ni && req_valid_i[p] &&
                       (req_we_i[p] || has_credit(count[p], infl[p]));
      end
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready_o = grant;
   assign sel         = grant[1];

   // Stage p0: drive the macro from the granted port, all zero when idle.
   always_comb begin
      sram_ce_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (|grant) begin
         sram_ce_o    = 1'b1;
         sram_we_o    = sel ? req_we_i[1] : req_we_i[0];
         sram_addr_o  = sel ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : req_addr_i[ADDR_WIDTH-1:0];
         sram_wdata_o = sel ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                            : req_wdata_i[DATA_WIDTH-1:0];
         sram_be_o    = sel ? req_be_i[2*DATA_WIDTH-1:DATA_WIDTH]
                            : req_be_i[DATA_WIDTH-1:0];
      end
   end

   assign read_issue = (|grant) && !sram_we_o;

   // Stage p0 -> p1: remember which port owns the read returning next cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr     <= 1'b0;
         rd_vld_p1  <= 1'b0;
         rd_port_p1 <= 1'b0;
      end else begin
         if (|grant) rr_ptr <= !grant[1];
         rd_vld_p1  <= read_issue;
         rd_port_p1 <= sel;
      end
   end

   assign push[0] = infl[0];
   assign push[1] = infl[1];
   assign pop     = rsp_valid_o & rsp_ready_i;

   // Stage p1 -> p2: response FIFO occupancy and pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int p = 0; p < 2; p++) begin
            count[p]  <= 2'd0;
            wr_ptr[p] <= 1'b0;
            rd_ptr[p] <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            assert (!(push[p] && count[p] == 2'd2))
               else $error("response FIFO overflow on port %0d", p);
            if (push[p]) wr_ptr[p] <= !wr_ptr[p];
            if (pop[p])  rd_ptr[p] <= !rd_ptr[p];
            case ({push[p], pop[p]})
               2'b10:   count[p] <= count[p] + 2'd1;
               2'b01:   count[p] <= count[p] - 2'd1;
               default: count[p] <= count[p];
            endcase
         end
      end
   end

   // Stage p1 -> p2: capture macro read data into the owning port's FIFO.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < 2; p++) begin
         if (push[p]) fifo_mem[p][wr_ptr[p]] <= sram_rdata_i;
      end
   end

   assign rsp_valid_o[0] = rst_ni && (count[0] != 2'd0);
   assign rsp_valid_o[1] = rst_ni && (count[1] != 2'd0);
   assign rsp_rdata_o    = {fifo_mem[1][rd_ptr[1]], fifo_mem[0][rd_ptr[0]]};

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a behavioural 1024x16 macro model.
module tb_sram_arbiter_2p;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata, req_be;
   logic [1:0]    rsp_valid, rsp_ready;
   logic [2*DW-1:0] rsp_rdata;
   logic          sram_ce, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, sram_be, sram_rdata;
   logic [DW-1:0] mem [1024];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
   );

   // Macro model: bit-masked write, registered read data one cycle later.
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_be) | (sram_wdata & sram_be);
         else         sram_rdata <= mem[sram_addr];
      end
   end

   task automatic drive(input int p, input logic v, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] b);
      req_valid[p]       = v;
      req_we[p]          = w;
      req_addr[p*AW +: AW] = a;
      req_wdata[p*DW +: DW] = d;
      req_be[p*DW +: DW] = b;
   endtask

   task automatic idle();
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 2'b11;
      drive(0, 1'b1, 1'b1, '0, '0, '0);
      drive(1, 1'b1, 1'b1, '0, '0, '0);
      repeat (3) begin
         @(negedge clk); #1;
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
         checks++; if (sram_ce !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL rst_ce_we got=%b%b exp=00", sram_ce, sram_we); end
         checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
      end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
      checks++; if (sram_ce !== 1'b1) begin failures++; $display("FAIL rst_first_ce got=%b exp=1", sram_ce); end
      @(negedge clk); idle();
   endtask

   task automatic test_write_read();
      @(negedge clk); drive(0, 1'b1, 1'b1, 10'h3FF, 16'hA5A5, 16'hFFFF); #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
      checks++; if ({sram_ce, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 10'h3FF, 16'hA5A5})
         begin failures++; $display("FAIL wr_macro got=%b %b %h %h exp=1 1 3ff a5a5", sram_ce, sram_we, sram_addr, sram_wdata); end
      @(negedge clk); drive(0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 16'hFFFF); #1;
      checks++; if (req_ready !== 2'b01 || sram_we !== 1'b0) begin failures++; $display("FAIL rd_grant got=%b we=%b exp=01 we=0", req_ready, sram_we); end
      @(negedge clk); idle(); #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rd_early got=%b exp=00", rsp_valid); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_rdata[15:0]} !== {2'b01, 16'hA5A5}) begin failures++; $display("FAIL rd_data got=%b %h exp=01 a5a5", rsp_valid, rsp_rdata[15:0]); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rd_popped got=%b exp=00", rsp_valid); end
   endtask

   task automatic test_bit_mask();
      @(negedge clk); drive(0, 1'b1, 1'b1, 10'd5, 16'hFFFF, 16'hFFFF);
      @(negedge clk); drive(0, 1'b1, 1'b1, 10'd5, 16'h0000, 16'h00FF);
      @(negedge clk); drive(0, 1'b1, 1'b0, 10'd5, 16'h0000, 16'h0000);
      @(negedge clk); idle();
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_rdata[15:0]} !== {2'b01, 16'hFF00}) begin failures++; $display("FAIL mask_data got=%b %h exp=01 ff00", rsp_valid, rsp_rdata[15:0]); end
   endtask

   task automatic test_contention();
      int idx [2];
      int rcv [2];
      logic [1:0] exp;
      logic [DW-1:0] want;
      // Preload addresses 0..7 and 0x100..0x107 with their own address.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(0, 1'b1, 1'b1, (i < 8) ? AW'(i) : AW'(256 + i - 8),
               (i < 8) ? DW'(i) : DW'(256 + i - 8), 16'hFFFF);
      end
      idx[0] = 0; idx[1] = 0; rcv[0] = 0; rcv[1] = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i < 16) begin
            drive(0, idx[0] < 8, 1'b0, AW'(idx[0]), '0, '0);
            drive(1, idx[1] < 8, 1'b0, AW'(256 + idx[1]), '0, '0);
         end else idle();
         #1;
         if (i < 16) begin
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if (req_ready !== exp) begin failures++; $display("FAIL cont_grant%0d got=%b exp=%b", i, req_ready, exp); end
            if (req_ready[0]) idx[0]++;
            if (req_ready[1]) idx[1]++;
         end
         for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p] === 1'b1) begin
               want = DW'(p * 256 + rcv[p]);
               checks++; if (rsp_rdata[p*DW +: DW] !== want) begin failures++; $display("FAIL cont_data p%0d got=%h exp=%h", p, rsp_rdata[p*DW +: DW], want); end
               rcv[p]++;
            end
         end
      end
      checks++; if (rcv[0] != 8 || rcv[1] != 8) begin failures++; $display("FAIL cont_count got=%0d,%0d exp=8,8", rcv[0], rcv[1]); end
   endtask

   task automatic test_backpressure();
      logic [1:0] exp_g [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      int idx1 = 0;
      rsp_ready = 2'b01;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(0, 1'b1, 1'b1, AW'(512 + i), 16'h1234, 16'hFFFF);
         drive(1, 1'b1, 1'b0, AW'(256 + idx1), '0, '0);
         #1;
         checks++; if (req_ready !== exp_g[i]) begin failures++; $display("FAIL bp_grant%0d got=%b exp=%b", i, req_ready, exp_g[i]); end
         if (req_ready[1]) idx1++;
      end
      checks++; if ({rsp_valid[1], rsp_rdata[31:16]} !== {1'b1, 16'h0100}) begin failures++; $display("FAIL bp_held got=%b %h exp=1 0100", rsp_valid[1], rsp_rdata[31:16]); end
      @(negedge clk);
      rsp_ready = 2'b11;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b1, 1'b0, 10'h102, '0, '0);
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_nocredit got=%b exp=00", req_ready); end
      checks++; if ({rsp_valid[1], rsp_rdata[31:16]} !== {1'b1, 16'h0100}) begin failures++; $display("FAIL bp_drain0 got=%b %h exp=1 0100", rsp_valid[1], rsp_rdata[31:16]); end
      @(negedge clk); #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_resume got=%b exp=10", req_ready); end
      checks++; if ({rsp_valid[1], rsp_rdata[31:16]} !== {1'b1, 16'h0101}) begin failures++; $display("FAIL bp_drain1 got=%b %h exp=1 0101", rsp_valid[1], rsp_rdata[31:16]); end
      @(negedge clk); idle(); #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_gap got=%b exp=00", rsp_valid); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_rdata[31:16]} !== {2'b10, 16'h0102}) begin failures++; $display("FAIL bp_new got=%b %h exp=10 0102", rsp_valid, rsp_rdata[31:16]); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_empty got=%b exp=00", rsp_valid); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk); drive(0, 1'b1, 1'b0, 10'd6, '0, '0); #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_grant got=%b exp=01", req_ready); end
      @(negedge clk); idle(); rst_n = 1'b0; #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mid_in_rst got=%b exp=00", rsp_valid); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mid_after%0d got=%b exp=00", i, rsp_valid); end
         @(negedge clk);
      end
      // Both credits must be back: two reads accepted with the response port stalled.
      rsp_ready = 2'b10;
      drive(0, 1'b1, 1'b0, 10'd6, '0, '0); #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_cred1 got=%b exp=01", req_ready); end
      @(negedge clk); drive(0, 1'b1, 1'b0, 10'd7, '0, '0); #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_cred2 got=%b exp=01", req_ready); end
      @(negedge clk); drive(0, 1'b1, 1'b0, 10'd3, '0, '0); #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_cred0 got=%b exp=00", req_ready); end
      @(negedge clk); idle(); rsp_ready = 2'b11; #1;
      checks++; if ({rsp_valid, rsp_rdata[15:0]} !== {2'b01, 16'h0006}) begin failures++; $display("FAIL mid_rsp6 got=%b %h exp=01 0006", rsp_valid, rsp_rdata[15:0]); end
      @(negedge clk); #1;
      checks++; if ({rsp_valid, rsp_rdata[15:0]} !== {2'b01, 16'h0007}) begin failures++; $display("FAIL mid_rsp7 got=%b %h exp=01 0007", rsp_valid, rsp_rdata[15:0]); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mid_empty got=%b exp=00", rsp_valid); end
   endtask

   initial begin
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 2'b11; rst_n = 1'b0;
      test_reset();
      test_write_read();
      test_bit_mask();
      test_contention();
      test_backpressure();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
